// File: rtl/uarc_bus_pkg.sv
// Shared types and helpers for the UARC bus responder.
package uarc_bus_pkg;

    localparam int unsigned UARC_WORD_MAG       = 5;
    localparam int unsigned UARC_FIFO_ADDR_WIDTH = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } uarc_state_t;

    function automatic int unsigned word_width(input int unsigned mag);
        return 32'(1) << mag;
    endfunction

    localparam int unsigned UARC_WORD_WIDTH = word_width(UARC_WORD_MAG);

    // FIFO entry at the default word width; stream=1 marks a streamed word
    typedef struct packed {
        logic                       stream;
        logic [UARC_WORD_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/uarc_fifo.sv
// Synchronous FIFO with flush; pushes are dropped while full, pops while empty.
module uarc_fifo #(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (ADDR_WIDTH+1)'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !reset) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/uarc_bus_responder.sv
// Receiving endpoint of one UARC bus: acks strobes, keeps incept context, queues words.
// Optional permission gating of send/stream enabled by `define UARC_RESP_PERM_CHECK_EN.
module uarc_bus_responder
    import uarc_bus_pkg::*;
#(
    parameter  int unsigned WORD_MAG        = UARC_WORD_MAG,
    parameter  int unsigned FIFO_ADDR_WIDTH = UARC_FIFO_ADDR_WIDTH,
    localparam int unsigned WORD_WIDTH      = word_width(WORD_MAG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bus_enable,
    input  logic                     global_kill,
    input  logic                     global_incept,
    input  logic                     global_send,
    input  logic                     global_stream,
    input  logic [WORD_WIDTH-1:0]    global_data,
    input  logic [WORD_WIDTH-1:0]    global_self_permission,
    input  logic [WORD_WIDTH-1:0]    global_self_address,
    input  logic [WORD_WIDTH-1:0]    global_incept_permission,
    input  logic [WORD_WIDTH-1:0]    global_incept_address,
    output logic                     kill_ack,
    output logic                     incept_ack,
    output logic                     send_ack,
    output logic                     stream_ack,
    output logic                     running,
    output logic [WORD_WIDTH-1:0]    ctx_permission,
    output logic [WORD_WIDTH-1:0]    ctx_address,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic                     out_stream,
`ifdef UARC_RESP_PERM_CHECK_EN
    output logic                     perm_violation,
`endif
    output logic [FIFO_ADDR_WIDTH:0] fifo_count
);

    uarc_state_t           r_state;
    uarc_state_t           w_state_next;
    logic [WORD_WIDTH-1:0] r_ctx_permission;
    logic [WORD_WIDTH-1:0] r_ctx_address;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_perm_ok;
    logic [WORD_WIDTH:0]   w_fifo_dout;
    // The sender address travels with each word on the bus but is not queued
    logic                  w_unused_addr;

    assign w_unused_addr = ^global_self_address;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (kill_ack)        w_state_next = IDLE;
        else if (incept_ack) w_state_next = RUNNING;
    end

    // Ack arbitration: kill beats everything; incept only in IDLE; send beats stream
    always_comb begin
        kill_ack   = 1'b0;
        incept_ack = 1'b0;
        send_ack   = 1'b0;
        stream_ack = 1'b0;
        if (!reset && bus_enable) begin
            if (global_kill) begin
                kill_ack = 1'b1;
            end else if (r_state == IDLE) begin
                incept_ack = global_incept;
            end else if (!w_full) begin
                if (global_send)        send_ack   = 1'b1;
                else if (global_stream) stream_ack = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || kill_ack) begin
            r_ctx_permission <= '0;
            r_ctx_address    <= '0;
        end else if (incept_ack) begin
            r_ctx_permission <= global_incept_permission;
            r_ctx_address    <= global_incept_address;
        end
    end

`ifdef UARC_RESP_PERM_CHECK_EN
    logic r_perm_violation;

    assign w_perm_ok = |(global_self_permission & r_ctx_permission);

    always_ff @(posedge clk) begin
        if (reset || kill_ack)                       r_perm_violation <= 1'b0;
        else if ((send_ack || stream_ack) && !w_perm_ok) r_perm_violation <= 1'b1;
    end

    assign perm_violation = r_perm_violation;
`else
    logic w_unused_perm;

    assign w_unused_perm = ^global_self_permission;
    assign w_perm_ok     = 1'b1;
`endif

    assign w_push = (send_ack || stream_ack) && w_perm_ok;
    assign w_pop  = !w_empty && out_ready;

    uarc_fifo #(
        .WIDTH      (WORD_WIDTH + 1),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (kill_ack),
        .din   ({stream_ack, global_data}),
        .dout  (w_fifo_dout),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign running        = (r_state == RUNNING);
    assign ctx_permission = r_ctx_permission;
    assign ctx_address    = r_ctx_address;
    assign out_valid      = !w_empty;
    assign out_data       = w_fifo_dout[WORD_WIDTH-1:0];
    assign out_stream     = w_fifo_dout[WORD_WIDTH];

endmodule

// File: tb/tb_uarc_bus_responder.sv
// Self-checking bench for uarc_bus_responder: queue-based model plus directed literal checks.
module tb_uarc_bus_responder;
    import uarc_bus_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_enable;
    logic          global_kill, global_incept, global_send, global_stream;
    logic [W-1:0]  global_data, global_self_permission, global_self_address;
    logic [W-1:0]  global_incept_permission, global_incept_address;
    logic          kill_ack, incept_ack, send_ack, stream_ack, running;
    logic [W-1:0]  ctx_permission, ctx_address, out_data;
    logic          out_valid, out_ready, out_stream;
    logic [3:0]    fifo_count;
`ifdef UARC_RESP_PERM_CHECK_EN
    logic          perm_violation;
`endif

    uarc_bus_responder dut (
        .clk                      (clk),
        .reset                    (reset),
        .bus_enable               (bus_enable),
        .global_kill              (global_kill),
        .global_incept            (global_incept),
        .global_send              (global_send),
        .global_stream            (global_stream),
        .global_data              (global_data),
        .global_self_permission   (global_self_permission),
        .global_self_address      (global_self_address),
        .global_incept_permission (global_incept_permission),
        .global_incept_address    (global_incept_address),
        .kill_ack                 (kill_ack),
        .incept_ack               (incept_ack),
        .send_ack                 (send_ack),
        .stream_ack               (stream_ack),
        .running                  (running),
        .ctx_permission           (ctx_permission),
        .ctx_address              (ctx_address),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_data                 (out_data),
        .out_stream               (out_stream),
`ifdef UARC_RESP_PERM_CHECK_EN
        .perm_violation           (perm_violation),
`endif
        .fifo_count               (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of entries plus the incept context
    bit           m_run;
    logic [W-1:0] m_perm, m_addr;
    bit           m_viol;
    bit           chk_en = 1'b0;
    fifo_entry_t  m_q[$];

    function automatic void model_acks(output bit k, output bit i, output bit s, output bit st);
        k = 0; i = 0; s = 0; st = 0;
        if (reset !== 1'b0 || bus_enable !== 1'b1) return;
        if (global_kill)                                  k  = 1;
        else if (!m_run && global_incept)                 i  = 1;
        else if (m_run && m_q.size() < DEPTH) begin
            if (global_send)        s  = 1;
            else if (global_stream) st = 1;
        end
    endfunction

    always @(posedge clk) begin
        bit k, i, s, st, ok;
        model_acks(k, i, s, st);
        if (reset) begin
            m_q.delete(); m_run = 0; m_perm = '0; m_addr = '0; m_viol = 0; chk_en = 1;
        end else if (k) begin
            m_q.delete(); m_run = 0; m_perm = '0; m_addr = '0; m_viol = 0;
        end else begin
            ok = 1;
`ifdef UARC_RESP_PERM_CHECK_EN
            ok = (global_self_permission & m_perm) != '0;
`endif
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (i) begin m_run = 1; m_perm = global_incept_permission; m_addr = global_incept_address; end
            if ((s || st) && ok) m_q.push_back('{stream: st, data: global_data});
            if ((s || st) && !ok) m_viol = 1;
        end
    end

    always @(negedge clk) begin
        bit k, i, s, st;
        if (chk_en) begin
            model_acks(k, i, s, st);
            check("kill_ack",   W'(kill_ack),   W'(k));
            check("incept_ack", W'(incept_ack), W'(i));
            check("send_ack",   W'(send_ack),   W'(s));
            check("stream_ack", W'(stream_ack), W'(st));
            check("running",    W'(running),    W'(m_run));
            check("ctx_perm",   ctx_permission, m_perm);
            check("ctx_addr",   ctx_address,    m_addr);
            check("fifo_count", W'(fifo_count), W'(m_q.size()));
            check("out_valid",  W'(out_valid),  W'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("out_data",   out_data,        m_q[0].data);
                check("out_stream", W'(out_stream),  W'(m_q[0].stream));
            end
`ifdef UARC_RESP_PERM_CHECK_EN
            check("perm_violation", W'(perm_violation), W'(m_viol));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input bit k, input bit i, input bit s, input bit st);
        global_kill = k; global_incept = i; global_send = s; global_stream = st;
    endtask

    initial begin
        reset = 1; bus_enable = 1; out_ready = 0;
        strobes(0, 0, 0, 0);
        global_data = '0; global_self_permission = 32'h0000_00F0; global_self_address = 32'h55;
        global_incept_permission = '0; global_incept_address = '0;
        tick(); tick();
        reset = 0;
        check("rst_running", W'(running), 0);
        check("rst_count",   W'(fifo_count), 0);
        check("rst_valid",   W'(out_valid), 0);
        check("rst_ctx",     ctx_permission, 0);

        // send in IDLE is held
        global_data = 32'hDEAD_0000; strobes(0, 0, 1, 0); #1;
        check("idle_send_ack", W'(send_ack), 0);
        tick();
        check("idle_send_count", W'(fifo_count), 0);

        // incept
        strobes(0, 1, 0, 0);
        global_incept_permission = 32'h0000_00F0; global_incept_address = 32'h0000_1234; #1;
        check("incept_ack", W'(incept_ack), 1);
        tick(); strobes(0, 0, 0, 0);
        check("incept_running", W'(running), 1);
        check("incept_perm", ctx_permission, 32'h0000_00F0);
        check("incept_addr", ctx_address, 32'h0000_1234);

        // send then stream
        global_data = 32'hA5A5_0001; strobes(0, 0, 1, 0); #1;
        check("send1_ack", W'(send_ack), 1);
        tick();
        global_data = 32'hA5A5_0002; strobes(0, 0, 0, 1); #1;
        check("stream1_ack", W'(stream_ack), 1);
        tick(); strobes(0, 0, 0, 0);
        check("two_count", W'(fifo_count), 2);
        check("head1_data", out_data, 32'hA5A5_0001);
        check("head1_stream", W'(out_stream), 0);
        out_ready = 1;
        tick();
        check("head2_data", out_data, 32'hA5A5_0002);
        check("head2_stream", W'(out_stream), 1);
        tick();
        check("drained_valid", W'(out_valid), 0);
        out_ready = 0;

        // fill to full
        for (int n = 0; n < 8; n++) begin
            global_data = 32'h100 + W'(n); strobes(0, 0, 1, 0); #1;
            check("fill_ack", W'(send_ack), 1);
            tick();
        end
        check("full_count", W'(fifo_count), 8);
        check("full_9th_ack", W'(send_ack), 0);
        tick();
        out_ready = 1; #1;
        check("full_pop_no_ack", W'(send_ack), 0);
        tick();
        out_ready = 0; #1;
        check("after_pop_ack", W'(send_ack), 1);
        check("after_pop_count", W'(fifo_count), 7);
        tick(); strobes(0, 0, 0, 0);
        check("refill_count", W'(fifo_count), 8);
        check("refill_head", out_data, 32'h101);

        // drain to 3 then kill+incept+send with a concurrent pop
        out_ready = 1;
        repeat (5) tick();
        out_ready = 0;
        check("three_count", W'(fifo_count), 3);
        out_ready = 1; strobes(1, 1, 1, 0); #1;
        check("kill_only_k", W'(kill_ack), 1);
        check("kill_only_i", W'(incept_ack), 0);
        check("kill_only_s", W'(send_ack), 0);
        tick(); strobes(0, 0, 0, 0); out_ready = 0;
        check("kill_running", W'(running), 0);
        check("kill_count", W'(fifo_count), 0);
        check("kill_ctx", ctx_permission, 0);

        // bus_enable low masks every strobe, in IDLE then in RUNNING
        bus_enable = 0; strobes(1, 1, 1, 1); #1;
        check("dis_idle_acks", W'({kill_ack, incept_ack, send_ack, stream_ack}), 0);
        tick();
        check("dis_idle_running", W'(running), 0);
        bus_enable = 1; strobes(0, 1, 0, 0);
        tick();
        bus_enable = 0; strobes(1, 1, 1, 1); #1;
        check("dis_run_acks", W'({kill_ack, incept_ack, send_ack, stream_ack}), 0);
        tick();
        bus_enable = 1; strobes(0, 0, 0, 0);
        check("dis_run_running", W'(running), 1);
        check("dis_run_count", W'(fifo_count), 0);

`ifdef UARC_RESP_PERM_CHECK_EN
        global_self_permission = 32'h0F; global_data = 32'hBAD0; strobes(0, 0, 1, 0); #1;
        check("perm_drop_ack", W'(send_ack), 1);
        tick(); strobes(0, 0, 0, 0);
        check("perm_drop_count", W'(fifo_count), 0);
        check("perm_violation", W'(perm_violation), 1);
        global_self_permission = 32'h10; global_data = 32'h600D; strobes(0, 0, 1, 0);
        tick(); strobes(0, 0, 0, 0);
        check("perm_ok_count", W'(fifo_count), 1);
        check("perm_ok_data", out_data, 32'h600D);
        global_self_permission = 32'hF0;
`endif

        // send beats stream
        global_data = 32'h77; strobes(0, 0, 1, 1); #1;
        check("prio_send", W'(send_ack), 1);
        check("prio_stream", W'(stream_ack), 0);
        tick();
        strobes(0, 0, 0, 1); global_data = 32'h78; out_ready = 1;
        tick(); strobes(0, 0, 0, 0);
        tick(); out_ready = 0;

        // reset mid-transfer
        global_data = 32'h99; strobes(0, 0, 1, 0);
        tick();
        reset = 1; #1;
        check("rst_mid_ack", W'(send_ack), 0);
        tick(); reset = 0; strobes(0, 0, 0, 0);
        check("rst_mid_running", W'(running), 0);
        check("rst_mid_count", W'(fifo_count), 0);
        check("rst_mid_ctx", ctx_address, 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
